// File: rtl/max_pool_h_pair.sv
// max_pool_h_pair: 2-wide stride-2 signed horizontal max-pool with pair repacking.
// Define MAX_POOL_H_CEIL_PAD_EN to keep an odd last-column feature (ceil mode).
module max_pool_h_pair #(
    parameter int feature_n_per_clk  = 4,
    parameter int feature_data_width = 16,
    parameter int simulation_delay   = 1
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [feature_n_per_clk*feature_data_width-1:0] s_axis_data,
    input  logic [feature_n_per_clk*feature_data_width/8-1:0] s_axis_keep,
    input  logic [2:0]                                     s_axis_user,
    input  logic                                           s_axis_last,
    input  logic                                           s_axis_valid,
    output logic                                           s_axis_ready,
    output logic [feature_n_per_clk*feature_data_width-1:0] m_axis_data,
    output logic [feature_n_per_clk*feature_data_width/8-1:0] m_axis_keep,
    output logic [2:0]                                     m_axis_user,
    output logic                                           m_axis_last,
    output logic                                           m_axis_valid,
    input  logic                                           m_axis_ready
);

    localparam int FN  = feature_n_per_clk;
    localparam int FW  = feature_data_width;
    localparam int BPF = FW / 8;
    localparam int HN  = FN / 2;
    localparam int KW  = $clog2(FN + 1);

    if (FN < 2 || (FN % 2) != 0) begin : g_bad_fn
        $error("feature_n_per_clk must be even and >= 2");
    end
    if (FW < 8 || (FW % 8) != 0) begin : g_bad_fw
        $error("feature_data_width must be a multiple of 8");
    end
    if (simulation_delay < 0) begin : g_bad_dly
        $error("simulation_delay must be non-negative");
    end

    typedef enum logic {
        HALF_EMPTY = 1'b0,
        HALF_FULL  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [HN*FW-1:0]  hreg;
    logic [KW-1:0]     k;
    logic [KW-1:0]     pc;
    logic [KW-1:0]     pcp;
    logic [HN*FW-1:0]  pz;
    logic [HN*BPF-1:0] pk;
    logic              accept;
    logic              last_col;
    logic              load_h;
    logic              emit;
    logic [FN*FW-1:0]  out_data;
    logic [FN*BPF-1:0] out_keep;
    logic              unused_keep;

    assign s_axis_ready = ~m_axis_valid | m_axis_ready;
    assign accept       = s_axis_valid & s_axis_ready;
    assign last_col     = s_axis_user[0];
    assign unused_keep  = ^s_axis_keep;

    // Only the first keep byte of each feature marks it valid.
    always_comb begin
        k = '0;
        for (int i = 0; i < FN; i++) begin
            k = k + KW'(s_axis_keep[i*BPF]);
        end
    end

    assign pc = k >> 1;
`ifdef MAX_POOL_H_CEIL_PAD_EN
    assign pcp = pc + KW'(k[0]);
`else
    assign pcp = pc;
`endif

    // Lane pc (only reachable in ceil mode) carries the lone feature.
    always_comb begin
        pz = '0;
        pk = '0;
        for (int i = 0; i < HN; i++) begin
            if (KW'(i) < pcp) begin
                if (($signed(s_axis_data[2*i*FW +: FW]) >=
                     $signed(s_axis_data[(2*i+1)*FW +: FW])) ||
                    (KW'(i) == pc)) begin
                    pz[i*FW +: FW] = s_axis_data[2*i*FW +: FW];
                end else begin
                    pz[i*FW +: FW] = s_axis_data[(2*i+1)*FW +: FW];
                end
                pk[i*BPF +: BPF] = '1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HALF_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            if (last_col) begin
                state_nxt = HALF_EMPTY;
            end else if (state == HALF_EMPTY) begin
                state_nxt = HALF_FULL;
            end else begin
                state_nxt = HALF_EMPTY;
            end
        end
    end

    always_comb begin
        load_h   = 1'b0;
        emit     = 1'b0;
        out_data = '0;
        out_keep = '0;
        if (accept) begin
            unique case (1'b1)
                (!last_col && state == HALF_EMPTY): begin
                    load_h = 1'b1;
                end
                (state == HALF_FULL): begin
                    emit     = 1'b1;
                    out_data = {pz, hreg};
                    out_keep = {pk, {(HN*BPF){1'b1}}};
                end
                default: begin
                    emit     = (pcp != '0);
                    out_data = {{(HN*FW){1'b0}}, pz};
                    out_keep = {{(HN*BPF){1'b0}}, pk};
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hreg <= '0;
        end else if (load_h) begin
            hreg <= pz;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_valid <= 1'b0;
            m_axis_data  <= '0;
            m_axis_keep  <= '0;
            m_axis_user  <= '0;
            m_axis_last  <= 1'b0;
        end else if (emit) begin
            m_axis_valid <= 1'b1;
            m_axis_data  <= out_data;
            m_axis_keep  <= out_keep;
            m_axis_user  <= s_axis_user;
            m_axis_last  <= s_axis_last;
        end else if (m_axis_ready) begin
            m_axis_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_max_pool_h_pair.sv
// tb_max_pool_h_pair: directed scoreboard bench for max_pool_h_pair (FN=4, FW=16).
// Honours MAX_POOL_H_CEIL_PAD_EN to pick ceil or floor expectations.
module tb_max_pool_h_pair;

`ifdef MAX_POOL_H_CEIL_PAD_EN
    localparam bit CEIL = 1'b1;
`else
    localparam bit CEIL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] s_axis_data;
    logic [7:0]  s_axis_keep;
    logic [2:0]  s_axis_user;
    logic        s_axis_last;
    logic        s_axis_valid;
    logic        s_axis_ready;
    logic [63:0] m_axis_data;
    logic [7:0]  m_axis_keep;
    logic [2:0]  m_axis_user;
    logic        m_axis_last;
    logic        m_axis_valid;
    logic        m_axis_ready;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  kp;
        logic [2:0]  u;
        logic        l;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   m_hold = 0;
    int   m_h[2];

    always #5 clk = ~clk;

    max_pool_h_pair #(
        .feature_n_per_clk (4),
        .feature_data_width(16),
        .simulation_delay  (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_axis_data (s_axis_data),
        .s_axis_keep (s_axis_keep),
        .s_axis_user (s_axis_user),
        .s_axis_last (s_axis_last),
        .s_axis_valid(s_axis_valid),
        .s_axis_ready(s_axis_ready),
        .m_axis_data (m_axis_data),
        .m_axis_keep (m_axis_keep),
        .m_axis_user (m_axis_user),
        .m_axis_last (m_axis_last),
        .m_axis_valid(m_axis_valid),
        .m_axis_ready(m_axis_ready)
    );

    function automatic int rnd();
        int v;
        v = int'($urandom_range(65535, 0));
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    function automatic exp_t put(exp_t e, int ln, int v);
        e.d[ln*16 +: 16] = 16'(v);
        e.kp[ln*2 +: 2]  = 2'b11;
        return e;
    endfunction

    task automatic model_beat(input int f0, input int f1, input int f2,
                              input int f3, input int k,
                              input logic [2:0] u, input logic l);
        int   f[4];
        int   pv[2];
        int   pc;
        int   lane;
        exp_t e;
        f  = '{f0, f1, f2, f3};
        pv = '{0, 0};
        pc = 0;
        for (int i = 0; i + 1 < k; i += 2) begin
            pv[pc] = (f[i] >= f[i+1]) ? f[i] : f[i+1];
            pc++;
        end
        if (CEIL && (k % 2 == 1)) begin
            pv[pc] = f[k-1];
            pc++;
        end
        e   = '0;
        e.u = u;
        e.l = l;
        if (!u[0]) begin
            if (m_hold == 0) begin
                m_h    = pv;
                m_hold = 1;
            end else begin
                e = put(e, 0, m_h[0]);
                e = put(e, 1, m_h[1]);
                e = put(e, 2, pv[0]);
                e = put(e, 3, pv[1]);
                sb.push_back(e);
                m_hold = 0;
            end
        end else begin
            lane = 0;
            if (m_hold != 0) begin
                e    = put(e, 0, m_h[0]);
                e    = put(e, 1, m_h[1]);
                lane = 2;
            end
            for (int j = 0; j < pc; j++) e = put(e, lane + j, pv[j]);
            if (lane + pc > 0) sb.push_back(e);
            m_hold = 0;
        end
    endtask

    task automatic send(input int f0, input int f1, input int f2,
                        input int f3, input int k,
                        input logic [2:0] u, input logic l);
        int f[4];
        int n;
        f = '{f0, f1, f2, f3};
        model_beat(f0, f1, f2, f3, k, u, l);
        s_axis_keep = '0;
        for (int i = 0; i < 4; i++) begin
            s_axis_data[i*16 +: 16] = (i < k) ? 16'(f[i]) : 16'($urandom);
            if (i < k) s_axis_keep[i*2 +: 2] = 2'b11;
        end
        s_axis_user  = u;
        s_axis_last  = l;
        s_axis_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axis_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        tests++;
        assert (n < 200) else begin
            fails++;
            $error("FAIL send_timeout: waited %0d want <200", n);
        end
        @(posedge clk);
        #1;
        s_axis_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        tests++;
        assert (m_axis_valid === 1'b0) else begin
            fails++;
            $error("FAIL %s_valid: got %b want 0", tag, m_axis_valid);
        end
        tests++;
        assert (m_axis_data === 64'h0) else begin
            fails++;
            $error("FAIL %s_data: got %h want 0", tag, m_axis_data);
        end
        tests++;
        assert ({m_axis_keep, m_axis_user, m_axis_last} === 12'h0) else begin
            fails++;
            $error("FAIL %s_kul: got %h/%b/%b want 0", tag,
                   m_axis_keep, m_axis_user, m_axis_last);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL drain: pending %0d want 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_idle(tag);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_hold = 0;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && m_axis_valid && m_axis_ready) begin
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL out_extra: got %h want none", m_axis_data);
            end
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                tests++;
                assert ({m_axis_data, m_axis_keep, m_axis_user, m_axis_last}
                        === mon_e) else begin
                    fails++;
                    $error("FAIL out_beat: got %h/%h/%b/%b want %h/%h/%b/%b",
                           m_axis_data, m_axis_keep, m_axis_user, m_axis_last,
                           mon_e.d, mon_e.kp, mon_e.u, mon_e.l);
                end
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        s_axis_data  = '0;
        s_axis_keep  = '0;
        s_axis_user  = '0;
        s_axis_last  = 1'b0;
        s_axis_valid = 1'b0;
        m_axis_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        tests++;
        assert (s_axis_ready === 1'b1) else begin
            fails++;
            $error("FAIL reset_sready: got %b want 1", s_axis_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(1, 5, -3, 2, 4, 3'b000, 1'b0);
        send(7, 0, 9, 9, 4, 3'b001, 1'b0);
        send(1, 2, 3, 4, 4, 3'b000, 1'b0);
        send(8, 6, 0, 0, 2, 3'b001, 1'b0);
        send(1, 2, 3, 4, 4, 3'b000, 1'b0);
        send(-7, 0, 0, 0, 1, 3'b001, 1'b0);
        send(-32768, 32767, -1, -2, 4, 3'b000, 1'b0);
        send(5, 5, 0, 0, 4, 3'b011, 1'b0);
        send(3, -4, 0, 0, 2, 3'b001, 1'b0);
        send(9, 0, 0, 0, 1, 3'b001, 1'b0);
        send(4, 6, -2, 0, 3, 3'b111, 1'b1);
        drain();

        m_axis_ready = 1'b0;
        fork
            begin
                repeat (10) @(posedge clk);
                #1;
                m_axis_ready = 1'b1;
            end
        join_none
        send(rnd(), rnd(), rnd(), rnd(), 4, 3'b000, 1'b0);
        send(rnd(), rnd(), rnd(), rnd(), 4, 3'b001, 1'b0);
        @(negedge clk);
        tests++;
        assert ({m_axis_valid, s_axis_ready} === 2'b10) else begin
            fails++;
            $error("FAIL stall: got valid/ready %b%b want 10",
                   m_axis_valid, s_axis_ready);
        end
        @(posedge clk);
        #1;
        for (int r = 0; r < 4; r++) begin
            send(rnd(), rnd(), rnd(), rnd(), 4, 3'b000, 1'b0);
            send(rnd(), rnd(), rnd(), rnd(), 4, 3'b001, 1'(r == 3));
        end
        drain();

        send(10, 20, 30, 40, 4, 3'b000, 1'b0);
        pulse_reset("rst_hold");
        send(1, 2, 3, 4, 4, 3'b000, 1'b0);
        send(8, 6, 0, 0, 2, 3'b001, 1'b0);
        drain();

        m_axis_ready = 1'b0;
        send(1, 1, 1, 1, 4, 3'b000, 1'b0);
        send(2, 2, 2, 2, 4, 3'b001, 1'b0);
        void'(sb.pop_back());
        pulse_reset("rst_out");
        m_axis_ready = 1'b1;
        @(negedge clk);
        tests++;
        assert (m_axis_valid === 1'b0) else begin
            fails++;
            $error("FAIL rst_out_stale: got %b want 0", m_axis_valid);
        end
        @(posedge clk);
        #1;
        send(-5, -9, 12, 11, 4, 3'b000, 1'b0);
        send(0, -1, 100, 200, 4, 3'b101, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
